// File: rtl/alu_normalizer_if.sv
// Start/busy/done handshake and data bus between the control unit and the ALU normalizer.
interface alu_normalizer_if #(
  parameter int WIDTH = 32,
  parameter int SH_W  = 6
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic             sign_mode;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [SH_W-1:0]  shamt;
  logic             zero;

  modport master (output start, a, sign_mode, input busy, done, result, shamt, zero);
  modport slave  (input start, a, sign_mode, output busy, done, result, shamt, zero);
endinterface

// File: rtl/alu_normalizer.sv
// Multi-cycle normalizer: finds the left-shift that normalizes an operand (unsigned or signed).
// Define ALU_NORMALIZER_FAST_EN to allow 4-bit steps when the top bits show it is safe.
module alu_normalizer #(
  parameter int WIDTH = 32,
  parameter int SH_W  = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  alu_normalizer_if.slave   bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] work_reg;
  logic [SH_W-1:0]  cnt_reg;
  logic             mode_reg;
  logic [WIDTH-1:0] result_reg;
  logic [SH_W-1:0]  shamt_reg;
  logic             zero_reg;

  logic             is_norm;
  logic [SH_W-1:0]  step;
  logic [WIDTH-1:0] work_shift;

  // Signed operands are normalized once the sign bit differs from the bit below it.
  assign is_norm = mode_reg ? (work_reg[WIDTH-1] ^ work_reg[WIDTH-2]) : work_reg[WIDTH-1];

`ifdef ALU_NORMALIZER_FAST_EN
  logic [3:0] top_eq;
  logic       big_step;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_top_eq
      assign top_eq[gi] = (work_reg[WIDTH-1-gi] == work_reg[WIDTH-2-gi]);
    end
  endgenerate

  // Four redundant leading bits guarantee at least four more single steps would follow.
  assign big_step   = mode_reg ? (&top_eq) : (work_reg[WIDTH-1 -: 4] == 4'b0000);
  assign step       = big_step ? SH_W'(4) : SH_W'(1);
  assign work_shift = big_step ? (work_reg << 4) : (work_reg << 1);
`else
  assign step       = SH_W'(1);
  assign work_shift = work_reg << 1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= ST_IDLE;
      work_reg   <= '0;
      cnt_reg    <= '0;
      mode_reg   <= 1'b0;
      result_reg <= '0;
      shamt_reg  <= '0;
      zero_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            work_reg  <= bus.a;
            cnt_reg   <= '0;
            mode_reg  <= bus.sign_mode;
            state_reg <= ST_SHIFT;
          end else begin
            state_reg <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (work_reg == '0) begin
            result_reg <= '0;
            shamt_reg  <= SH_W'(WIDTH);
            zero_reg   <= 1'b1;
            state_reg  <= ST_DONE;
          end else if (is_norm) begin
            result_reg <= work_reg;
            shamt_reg  <= cnt_reg;
            zero_reg   <= 1'b0;
            state_reg  <= ST_DONE;
          end else begin
            work_reg <= work_shift;
            cnt_reg  <= cnt_reg + step;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy   = (state_reg == ST_SHIFT);
  assign bus.done   = (state_reg == ST_DONE);
  assign bus.result = result_reg;
  assign bus.shamt  = shamt_reg;
  assign bus.zero   = zero_reg;

endmodule

// File: tb/tb_alu_normalizer.sv
// Self-checking bench for alu_normalizer: spec vectors, handshake corner cases, random vs. model.
module tb_alu_normalizer;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  alu_normalizer_if #(.WIDTH(32), .SH_W(6)) bus ();

  alu_normalizer #(.WIDTH(32), .SH_W(6)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic        sm;
    logic [31:0] r;
    int          sh;
    logic        z;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference: count redundant leading bits directly from the operand.
  task automatic ref_norm(input logic [31:0] av, input logic sm,
                          output logic [31:0] r, output int sh, output logic z);
    int lead;
    if (av == 32'd0) begin
      r = 32'd0; sh = 32; z = 1'b1;
    end else begin
      if (!sm) begin
        lead = 0;
        while (av[31-lead] == 1'b0) lead++;
        sh = lead;
      end else begin
        lead = 1;
        while (lead < 32 && av[31-lead] == av[31]) lead++;
        sh = lead - 1;
      end
      r = av << sh;
      z = 1'b0;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the done cycle (or on timeout).
  task automatic do_op(input logic [31:0] av, input logic sm, output int n, output logic busy_ok);
    bus.start = 1'b1; bus.a = av; bus.sign_mode = sm;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.a = $urandom; bus.sign_mode = ~sm;
    n = 1;
    busy_ok = bus.busy;
    while (!bus.done && n < 80) begin
      @(posedge clk); #1;
      n++;
      if (!bus.done && !bus.busy) busy_ok = 1'b0;
    end
  endtask

  task automatic check_op(input string tag, input logic [31:0] av, input logic sm,
                          input logic [31:0] er, input int esh, input logic ez,
                          input int n, input logic busy_ok);
    int k;
    k = ez ? 0 : esh;
    $display("op %s a=0x%08h sm=%0d result=0x%08h shamt=%0d zero=%0d edges=%0d",
             tag, av, sm, bus.result, bus.shamt, bus.zero, n);
    chk({tag, " done_seen"}, 64'(bus.done), 64'd1);
    chk({tag, " result"}, 64'(bus.result), 64'(er));
    chk({tag, " shamt"}, 64'(bus.shamt), 64'(esh));
    chk({tag, " zero"}, 64'(bus.zero), 64'(ez));
    chk({tag, " busy_in_done"}, 64'(bus.busy), 64'd0);
    chk({tag, " busy_held"}, 64'(busy_ok), 64'd1);
`ifdef ALU_NORMALIZER_FAST_EN
    chk({tag, " shift_cycles_le12"}, 64'((n - 1) <= 12), 64'd1);
`else
    chk({tag, " latency"}, 64'(n), 64'(k + 2));
`endif
  endtask

  initial begin
    int          n;
    logic        busy_ok;
    logic [31:0] av, er;
    logic        sm, ez;
    int          esh;
    logic        saw_done, saw_busy;

    checks = 0;
    failures = 0;

    vecs[0] = '{32'h0001_0000, 1'b0, 32'h8000_0000, 15, 1'b0};
    vecs[1] = '{32'h0000_0000, 1'b0, 32'h0000_0000, 32, 1'b1};
    vecs[2] = '{32'h0000_0000, 1'b1, 32'h0000_0000, 32, 1'b1};
    vecs[3] = '{32'h0000_0003, 1'b1, 32'h6000_0000, 29, 1'b0};
    vecs[4] = '{32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 31, 1'b0};
    vecs[5] = '{32'h4000_0000, 1'b1, 32'h4000_0000,  0, 1'b0};
    vecs[6] = '{32'h0000_0001, 1'b0, 32'h8000_0000, 31, 1'b0};
    vecs[7] = '{32'h8000_0000, 1'b0, 32'h8000_0000,  0, 1'b0};
    vecs[8] = '{32'hC000_0000, 1'b1, 32'h8000_0000,  1, 1'b0};
    vecs[9] = '{32'hFFFF_8000, 1'b1, 32'h8000_0000, 16, 1'b0};

    reset_n = 1'b1;
    bus.start = 1'b0; bus.a = '0; bus.sign_mode = 1'b0;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset done", 64'(bus.done), 64'd0);
    chk("reset result", 64'(bus.result), 64'd0);
    chk("reset shamt", 64'(bus.shamt), 64'd0);
    chk("reset zero", 64'(bus.zero), 64'd0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    // Spec vectors, issued back-to-back (each start lands in the previous DONE cycle).
    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].a, vecs[i].sm, n, busy_ok);
      check_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].sm, vecs[i].r, vecs[i].sh, vecs[i].z, n, busy_ok);
    end
    @(posedge clk); #1;
    chk("done_one_cycle", 64'(bus.done), 64'd0);
    chk("idle_not_busy", 64'(bus.busy), 64'd0);

    // start during SHIFT is ignored; start in DONE is accepted.
    bus.start = 1'b1; bus.a = 32'h0000_0001; bus.sign_mode = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.a = 32'h0001_0000; bus.sign_mode = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 7;
    while (!bus.done && n < 80) begin @(posedge clk); #1; n++; end
    $display("op ignore_start result=0x%08h shamt=%0d edges=%0d", bus.result, bus.shamt, n);
    chk("ignore done_seen", 64'(bus.done), 64'd1);
    chk("ignore shamt", 64'(bus.shamt), 64'd31);
    chk("ignore result", 64'(bus.result), 64'h8000_0000);
    bus.start = 1'b1; bus.a = 32'h8000_0000; bus.sign_mode = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("b2b edge1 done", 64'(bus.done), 64'd0);
    chk("b2b edge1 busy", 64'(bus.busy), 64'd1);
    @(posedge clk); #1;
    $display("op back_to_back result=0x%08h shamt=%0d done=%0d", bus.result, bus.shamt, bus.done);
    chk("b2b edge2 done", 64'(bus.done), 64'd1);
    chk("b2b shamt", 64'(bus.shamt), 64'd0);
    chk("b2b result", 64'(bus.result), 64'h8000_0000);

    // Reset mid-operation clears outputs at once and suppresses done.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.a = 32'h0000_0001; bus.sign_mode = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    $display("op reset_mid result=0x%08h shamt=%0d busy=%0d", bus.result, bus.shamt, bus.busy);
    chk("midreset busy", 64'(bus.busy), 64'd0);
    chk("midreset done", 64'(bus.done), 64'd0);
    chk("midreset result", 64'(bus.result), 64'd0);
    chk("midreset shamt", 64'(bus.shamt), 64'd0);
    chk("midreset zero", 64'(bus.zero), 64'd0);
    @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    saw_done = 1'b0; saw_busy = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) saw_done = 1'b1;
      if (bus.busy) saw_busy = 1'b1;
    end
    chk("midreset no_done", 64'(saw_done), 64'd0);
    chk("midreset stays_idle", 64'(saw_busy), 64'd0);
    do_op(32'h0000_0003, 1'b1, n, busy_ok);
    check_op("after_reset", 32'h0000_0003, 1'b1, 32'h6000_0000, 29, 1'b0, n, busy_ok);

    // Random operands in both modes against the reference model.
    for (int i = 0; i < 1000; i++) begin
      sm = 1'(i % 2);
      av = $urandom >> $urandom_range(0, 31);
      if (sm && $urandom_range(0, 1) == 1) av = ~av;
      if ($urandom_range(0, 49) == 0) av = 32'd0;
      ref_norm(av, sm, er, esh, ez);
      do_op(av, sm, n, busy_ok);
      check_op($sformatf("rnd%0d", i), av, sm, er, esh, ez, n, busy_ok);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
